// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction-memory request/response, branch redirect and
// head-of-queue delivery to the datapath.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  logic                   imem_req;
  logic [31:0]            imem_addr;
  logic                   imem_ack;
  logic [31:0]            imem_data;
  logic                   redirect;
  logic [31:0]            redirect_pc;
  logic                   instr_valid;
  logic [31:0]            instr;
  logic [31:0]            instr_pc;
  logic                   instr_ready;
  logic [$clog2(DEPTH):0] count;

  // The fetch queue itself drives requests and the head entry.
  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_data,
    input  redirect, redirect_pc,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    output count
  );

  // Memory and datapath side.
  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_data,
    output redirect, redirect_pc,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    input  count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches to instruction
// memory, buffers {pc, instr} pairs in a DEPTH-entry circular queue and
// restarts the stream on a redirect, discarding any in-flight stale response.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic           clk,
  input logic           reset,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_req;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_addr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [63:0]   r_mem [DEPTH];

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;
  logic [31:0]   w_pc_inc;

  // A response is only accepted for a fresh request; a redirect kills it.
  assign w_push   = (r_state == ST_REQ) && bus.imem_ack && !bus.redirect;
  assign w_pop    = (r_count != {CW{1'b0}}) && bus.instr_ready && !bus.redirect;
  assign w_pc_inc = r_fetch_pc + 32'd1;

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_req_addr;
  assign bus.count       = r_count;
  assign bus.instr_valid = (r_count != {CW{1'b0}});
  assign {bus.instr_pc, bus.instr} = r_mem[r_rd_ptr];

  // Occupancy after this cycle's push/pop, used to stop fetching when full.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1'b1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1'b1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Queue storage: write the {address, data} pair of an accepted response.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= {bus.imem_addr, bus.imem_data};
    end
  end

  // Fetch FSM and queue bookkeeping; redirect flushes and overrides push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_req      <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_rd_ptr   <= {AW{1'b0}};
      r_wr_ptr   <= {AW{1'b0}};
      r_count    <= {CW{1'b0}};
    end else begin
      if (bus.redirect) begin
        r_rd_ptr <= {AW{1'b0}};
        r_wr_ptr <= {AW{1'b0}};
        r_count  <= {CW{1'b0}};
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1'b1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1'b1);
        r_count <= w_count_nxt;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.redirect) begin
            r_fetch_pc <= bus.redirect_pc;
            r_req_addr <= bus.redirect_pc;
            r_state    <= ST_REQ;
            r_req      <= 1'b1;
          end else if (r_count < FULL_CNT) begin
            r_req_addr <= r_fetch_pc;
            r_state    <= ST_REQ;
            r_req      <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
          end
        end
        ST_REQ: begin
          if (bus.redirect && bus.imem_ack) begin
            // Old response arrives with the redirect: drop it, go straight on.
            r_fetch_pc <= bus.redirect_pc;
            r_req_addr <= bus.redirect_pc;
            r_state    <= ST_REQ;
            r_req      <= 1'b1;
          end else if (bus.redirect) begin
            // Request still in flight: keep its address until it is acked.
            r_fetch_pc <= bus.redirect_pc;
            r_state    <= ST_DROP;
            r_req      <= 1'b1;
          end else if (bus.imem_ack) begin
            r_fetch_pc <= w_pc_inc;
            r_req_addr <= w_pc_inc;
            if (w_count_nxt == FULL_CNT) begin
              r_state <= ST_IDLE;
              r_req   <= 1'b0;
            end else begin
              r_state <= ST_REQ;
              r_req   <= 1'b1;
            end
          end else begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
          end
        end
        ST_DROP: begin
          if (bus.imem_ack) begin
            if (bus.redirect) begin
              r_fetch_pc <= bus.redirect_pc;
              r_req_addr <= bus.redirect_pc;
            end else begin
              r_req_addr <= r_fetch_pc;
            end
            r_state <= ST_REQ;
            r_req   <= 1'b1;
          end else begin
            if (bus.redirect) begin
              r_fetch_pc <= bus.redirect_pc;
            end
            r_state <= ST_DROP;
            r_req   <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios followed by
// randomized traffic, all checked against a stream-level reference model
// (expected-pc queue plus next fetch address).
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  always_comb bus.imem_data = mem_word(bus.imem_addr);

  // Reference model state
  logic [31:0] m_q[$];   // pcs expected at the head, in delivery order
  logic [31:0] m_fetch;  // address of the next fresh request
  logic        m_stale;  // outstanding request belongs to a flushed stream
  logic        m_known = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check outputs against the model, advance the model with the inputs
  // currently applied, then move to the next sampling point.
  task automatic tick();
    if (m_known) begin
      check("count", 64'(bus.count), 64'(m_q.size()));
      check("instr_valid", 64'(bus.instr_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        check("instr_pc", 64'(bus.instr_pc), 64'(m_q[0]));
        check("instr", 64'(bus.instr), 64'(mem_word(m_q[0])));
      end
      if (bus.imem_req && !m_stale) check("imem_addr", 64'(bus.imem_addr), 64'(m_fetch));
      if (m_q.size() == DEPTH) check("req_when_full", 64'(bus.imem_req), 64'd0);
    end
    if (reset) begin
      m_q.delete();
      m_fetch = RESET_PC;
      m_stale = 1'b0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (bus.redirect) begin
        m_q.delete();
        m_fetch = bus.redirect_pc;
        m_stale = bus.imem_req && !bus.imem_ack;
      end else begin
        if (m_q.size() != 0 && bus.instr_ready) void'(m_q.pop_front());
        if (bus.imem_req && bus.imem_ack) begin
          if (!m_stale) begin
            m_q.push_back(m_fetch);
            m_fetch = m_fetch + 32'd1;
          end
          m_stale = 1'b0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    bus.imem_ack = 1'b1;
    bus.instr_ready = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    @(negedge clk);

    // Reset state, then zero-wait streaming
    tick();
    tick();
    check("rst_req", 64'(bus.imem_req), 64'd0);
    check("rst_valid", 64'(bus.instr_valid), 64'd0);
    check("rst_count", 64'(bus.count), 64'd0);
    reset = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("stream_req", 64'(bus.imem_req), 64'd1);
      check("stream_addr", 64'(bus.imem_addr), 64'(k));
      if (k > 0) begin
        check("stream_valid", 64'(bus.instr_valid), 64'd1);
        check("stream_pc", 64'(bus.instr_pc), 64'(k - 1));
      end
      tick();
    end

    // Fill to DEPTH with the consumer stalled, then release it
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.instr_ready = 1'b0;
    tick();
    for (int i = 0; i < 12 && int'(bus.count) != DEPTH; i++) tick();
    check("full_count", 64'(bus.count), 64'(DEPTH));
    check("full_req", 64'(bus.imem_req), 64'd0);
    tick();
    check("full_req_hold", 64'(bus.imem_req), 64'd0);
    bus.instr_ready = 1'b1;
    check("full_head_pc", 64'(bus.instr_pc), 64'd0);
    for (int i = 0; i < 6 && !bus.imem_req; i++) tick();
    check("resume_req", 64'(bus.imem_req), 64'd1);
    check("resume_addr", 64'(bus.imem_addr), 64'd4);
    check("resume_count", 64'(bus.count), 64'd2);

    // Wait states: address holds, one push on the late ack
    bus.imem_ack = 1'b0;
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_addr", 64'(bus.imem_addr), 64'd4);
      check("wait_req", 64'(bus.imem_req), 64'd1);
    end
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    check("wait_push", 64'(bus.count), 64'd3);

    // Redirect while waiting: drop the late response
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    bus.redirect = 1'b0;
    check("drop_count", 64'(bus.count), 64'd0);
    check("drop_req", 64'(bus.imem_req), 64'd1);
    check("drop_addr_old", 64'(bus.imem_addr), 64'd5);
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    check("drop_discard", 64'(bus.count), 64'd0);
    check("drop_new_addr", 64'(bus.imem_addr), 64'h40);

    // Redirect coinciding with ack and pop
    bus.imem_ack = 1'b1;
    tick();
    tick();
    check("pre_redir_count", 64'(bus.count), 64'd2);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h80;
    bus.instr_ready = 1'b1;
    tick();
    bus.redirect = 1'b0;
    check("redir_count", 64'(bus.count), 64'd0);
    check("redir_addr", 64'(bus.imem_addr), 64'h80);
    tick();
    check("redir_valid", 64'(bus.instr_valid), 64'd1);
    check("redir_pc", 64'(bus.instr_pc), 64'h80);

    // Reset while in DROP
    bus.imem_ack = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h100;
    tick();
    bus.redirect = 1'b0;
    check("pre_rst_drop_req", 64'(bus.imem_req), 64'd1);
    reset = 1'b1;
    bus.imem_ack = 1'b1;
    tick();
    check("rst_drop_req", 64'(bus.imem_req), 64'd0);
    check("rst_drop_count", 64'(bus.count), 64'd0);
    reset = 1'b0;
    bus.imem_ack = 1'b0;
    tick();
    check("restart_req", 64'(bus.imem_req), 64'd1);
    check("restart_addr", 64'(bus.imem_addr), 64'(RESET_PC));

    // Zero-wait throughput: one delivery per cycle once primed
    bus.imem_ack = 1'b1;
    bus.instr_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c > 2) begin
        check("tput_req", 64'(bus.imem_req), 64'd1);
        check("tput_valid", 64'(bus.instr_valid), 64'd1);
      end
      tick();
    end

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      bus.redirect = ($urandom_range(0, 15) == 0);
      bus.redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      bus.imem_ack = $urandom_range(0, 1) == 1;
      bus.instr_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    reset = 1'b0;
    bus.redirect = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: queue entries, power of two, minimum 2.
REQ-002 Parameter RESET_PC, default 32'h0: first word address fetched after reset.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port imem_req  output  1: fetch request to instruction memory.
REQ-006 Port imem_addr  output  32: word address of the outstanding request.
REQ-007 Port imem_ack  input  1: memory response valid; completes the request in the cycle it is high with imem_req.
REQ-008 Port imem_data  input  32: instruction word, valid when imem_ack is high.
REQ-009 Port redirect  input  1: branch taken; flush the queue and restart at redirect_pc.
REQ-010 Port redirect_pc  input  32: word address of the new fetch stream.
REQ-011 Port instr_valid  output  1: head entry available to the datapath.
REQ-012 Port instr  output  32: head instruction.
REQ-013 Port instr_pc  output  32: word address of the head instruction.
REQ-014 Port instr_ready  input  1: datapath consumes the head when high with instr_valid.
REQ-015 Port count  output  $clog2(DEPTH)+1: number of queued entries.

Function
REQ-016 Addresses are word addresses: the sequential next address is fetch_pc+1, wrapping modulo 2^32.
REQ-017 The FSM has three states: IDLE (imem_req=0), REQ (imem_req=1, fresh request), DROP (imem_req=1, response to be discarded).
REQ-018 imem_addr shall come from a request-address register and stay stable from the first cycle imem_req is high until the cycle imem_ack is sampled high.
REQ-019 IDLE: if redirect, fetch_pc<=redirect_pc, flush, next state REQ; else if count<DEPTH, latch fetch_pc into the request-address register, next state REQ.
REQ-020 REQ with imem_ack and no redirect: push {imem_addr, imem_data}, fetch_pc<=fetch_pc+1, latch the next address; stay REQ if the next-cycle count<DEPTH, else go IDLE.
REQ-021 REQ with imem_ack=0 and no redirect: hold the state, the address, and imem_req.
REQ-022 REQ with redirect and imem_ack=0: flush, fetch_pc<=redirect_pc, go DROP; imem_addr keeps the old address.
REQ-023 REQ with redirect and imem_ack=1: discard imem_data, flush, latch redirect_pc as the next request address, stay REQ.
REQ-024 DROP with imem_ack=1: discard imem_data, latch fetch_pc (updated by any same-cycle redirect), go REQ.
REQ-025 DROP with imem_ack=0 and redirect: fetch_pc<=redirect_pc, stay DROP.
REQ-026 Zero-wait memory (imem_ack tied high) shall sustain one push per cycle while instr_ready is high.
REQ-027 instr_valid=(count!=0); instr and instr_pc show the head entry and stay stable while instr_valid=1 and instr_ready=0.
REQ-028 Pop occurs when instr_valid&&instr_ready; if a push and a pop occur in the same cycle, count is unchanged.
REQ-029 Redirect overrides any same-cycle push and pop: count<=0, and only the redirect_pc stream is delivered afterwards.
REQ-030 No push occurs while count==DEPTH (guaranteed by REQ-019/020); read and write pointers wrap modulo DEPTH.
REQ-031 Entries are delivered in fetch order; none is ever duplicated or skipped within a stream.

Reset
REQ-032 While reset is high: state IDLE, count=0, pointers=0, fetch_pc=RESET_PC, imem_req=0, instr_valid=0; reset overrides redirect and imem_ack.
REQ-033 Reset asserted mid-request returns to IDLE; any later imem_ack for that request is ignored.
REQ-034 After reset falls, imem_req rises one cycle later with imem_addr=RESET_PC.

Verification
REQ-035 Reset, imem_ack=1, instr_ready=1 -> imem_addr 0,1,2,3 on consecutive cycles; instr_pc 0,1,2 on consecutive cycles with instr_valid continuously high.
REQ-036 instr_ready=0, imem_ack=1 -> count rises to 4, imem_req drops; set instr_ready=1 -> head instr_pc=0 and fetching resumes at address 4.
REQ-037 imem_ack held low 3 cycles -> imem_addr stable for all 3 cycles; ack on the 4th cycle pushes exactly one entry.
REQ-038 redirect with redirect_pc=0x40 while waiting for ack -> count=0, DROP; the late ack data is not queued; next imem_addr=0x40.
REQ-039 redirect with redirect_pc=0x80 in the same cycle as ack and pop with count=2 -> next cycle count=0; next imem_addr=0x80; the first delivered instr_pc=0x80.
REQ-040 Reset asserted in the DROP state -> next cycle IDLE, count=0; fetching restarts at RESET_PC.
